// File: rtl/fft_bf_sched_pkg.sv
// Shared constants and FSM encoding for the radix-2 DIT butterfly scheduler.
package fft_bf_sched_pkg;

  localparam int CPLX_WIDTH   = 16;
  localparam int DEF_LOG2N    = 8;
  localparam int DEF_PIPE_LAT = 4;

  typedef enum logic [1:0] {
    SCHED_IDLE  = 2'd0,
    SCHED_RUN   = 2'd1,
    SCHED_DRAIN = 2'd2,
    SCHED_DONE  = 2'd3
  } sched_state_e;

endpackage

// File: rtl/fft_bf_sched_delay.sv
// PIPE_LAT-stage delay line turning read strobes/addresses into write-back strobes/addresses.
module bf_addr_delay #(
  parameter int AW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          in_valid,
  input  logic [AW-1:0] in_addr_a,
  input  logic [AW-1:0] in_addr_b,
  output logic          out_valid,
  output logic [AW-1:0] out_addr_a,
  output logic [AW-1:0] out_addr_b
);

  localparam int W = 1 + 2 * AW;

  logic [W-1:0] pipe_reg [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) pipe_reg[i] <= '0;
    end else if (en) begin
      pipe_reg[0] <= {in_valid, in_addr_a, in_addr_b};
      for (int i = 1; i < DEPTH; i++) pipe_reg[i] <= pipe_reg[i-1];
    end
  end

  assign {out_valid, out_addr_a, out_addr_b} = pipe_reg[DEPTH-1];

endmodule

// File: rtl/fft_bf_sched.sv
// In-place radix-2 DIT FFT stage/butterfly scheduler with delayed write-back addresses.
// Optional stall input enabled by defining FFT_SCHED_STALL_EN.
module fft_bf_sched
  import fft_bf_sched_pkg::*;
#(
  parameter int LOG2N    = DEF_LOG2N,
  parameter int PIPE_LAT = DEF_PIPE_LAT
) (
  input  logic                       clk,
  input  logic                       rst,
`ifdef FFT_SCHED_STALL_EN
  input  logic                       hold,
`endif
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       rd_en,
  output logic [LOG2N-1:0]           rd_addr_a,
  output logic [LOG2N-1:0]           rd_addr_b,
  output logic [LOG2N-2:0]           tw_addr,
  output logic                       wr_en,
  output logic [LOG2N-1:0]           wr_addr_a,
  output logic [LOG2N-1:0]           wr_addr_b,
  output logic [$clog2(LOG2N)-1:0]   stage
);

  localparam int AW = LOG2N;
  localparam int KW = LOG2N - 1;
  localparam int SW = $clog2(LOG2N);
  localparam int DW = $clog2(PIPE_LAT + 1);

  sched_state_e  state_reg, state_next;
  logic [KW-1:0] k_reg, k_next;
  logic [DW-1:0] drain_reg, drain_next;
  logic [SW-1:0] stage_reg, stage_next;

  logic          run_en;
  logic          issue;
  logic          busy_reg, done_reg, rd_en_reg;
  logic [AW-1:0] rd_addr_a_reg, rd_addr_b_reg;
  logic [KW-1:0] tw_reg;
  logic [SW-1:0] stage_out_reg;
  logic          wr_valid;

  logic [AW-1:0] span, k_ext, pos, grp, addr_a, addr_b;
  logic [SW-1:0] tw_shift;
  logic [KW-1:0] tw_calc;

`ifdef FFT_SCHED_STALL_EN
  assign run_en = ~hold;
`else
  assign run_en = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= SCHED_IDLE;
      k_reg     <= '0;
      drain_reg <= '0;
      stage_reg <= '0;
    end else if (run_en) begin
      state_reg <= state_next;
      k_reg     <= k_next;
      drain_reg <= drain_next;
      stage_reg <= stage_next;
    end
  end

  // done_reg blocks a start landing on the done cycle from being taken in IDLE
  always_comb begin
    state_next = state_reg;
    k_next     = k_reg;
    drain_next = drain_reg;
    stage_next = stage_reg;
    case (state_reg)
      SCHED_IDLE: begin
        if (start && !done_reg) begin
          state_next = SCHED_RUN;
          k_next     = '0;
          stage_next = '0;
        end
      end
      SCHED_RUN: begin
        if (&k_reg) begin
          state_next = SCHED_DRAIN;
          drain_next = '0;
        end else begin
          k_next = k_reg + KW'(1);
        end
      end
      SCHED_DRAIN: begin
        if (drain_reg == DW'(PIPE_LAT - 1)) begin
          if (stage_reg == SW'(LOG2N - 1)) begin
            state_next = SCHED_DONE;
          end else begin
            state_next = SCHED_RUN;
            stage_next = stage_reg + SW'(1);
            k_next     = '0;
          end
        end else begin
          drain_next = drain_reg + DW'(1);
        end
      end
      SCHED_DONE: state_next = SCHED_IDLE;
      default:    state_next = SCHED_IDLE;
    endcase
  end

  assign issue = (state_reg == SCHED_RUN);

  // Butterfly k of stage s: insert a zero at bit s of k to get the upper operand
  always_comb begin
    span     = AW'(1) << stage_reg;
    k_ext    = {1'b0, k_reg};
    pos      = k_ext & (span - AW'(1));
    grp      = k_ext >> stage_reg;
    addr_a   = ((grp << stage_reg) << 1) | pos;
    addr_b   = addr_a + span;
    tw_shift = SW'(LOG2N - 1) - stage_reg;
    tw_calc  = KW'(pos << tw_shift);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      rd_en_reg     <= 1'b0;
      rd_addr_a_reg <= '0;
      rd_addr_b_reg <= '0;
      tw_reg        <= '0;
      stage_out_reg <= '0;
    end else if (run_en) begin
      busy_reg      <= (state_reg == SCHED_RUN) || (state_reg == SCHED_DRAIN);
      done_reg      <= (state_reg == SCHED_DONE);
      rd_en_reg     <= issue;
      stage_out_reg <= stage_reg;
      if (issue) begin
        rd_addr_a_reg <= addr_a;
        rd_addr_b_reg <= addr_b;
        tw_reg        <= tw_calc;
      end
    end
  end

  bf_addr_delay #(
    .AW    (AW),
    .DEPTH (PIPE_LAT)
  ) u_delay (
    .clk        (clk),
    .rst        (rst),
    .en         (run_en),
    .in_valid   (rd_en_reg),
    .in_addr_a  (rd_addr_a_reg),
    .in_addr_b  (rd_addr_b_reg),
    .out_valid  (wr_valid),
    .out_addr_a (wr_addr_a),
    .out_addr_b (wr_addr_b)
  );

  assign busy      = busy_reg;
  assign done      = done_reg & run_en;
  assign rd_en     = rd_en_reg & run_en;
  assign wr_en     = wr_valid & run_en;
  assign rd_addr_a = rd_addr_a_reg;
  assign rd_addr_b = rd_addr_b_reg;
  assign tw_addr   = tw_reg;
  assign stage     = stage_out_reg;

endmodule

// File: tb/tb_fft_bf_sched.sv
// Self-checking bench for fft_bf_sched: N=8/PIPE_LAT=4 and N=4/PIPE_LAT=1 instances vs a pair-enumeration model.
module tb_fft_bf_sched;

  localparam int L0 = 3, P0 = 4;
  localparam int L1 = 2, P1 = 1;

  logic clk = 1'b0;
  logic rst, start0, start1;
`ifdef FFT_SCHED_STALL_EN
  logic hold;
`endif

  logic busy0, done0, rd_en0, wr_en0;
  logic [L0-1:0] ra0, rb0, wa0, wb0;
  logic [L0-2:0] tw0;
  logic [$clog2(L0)-1:0] st0;

  logic busy1, done1, rd_en1, wr_en1;
  logic [L1-1:0] ra1, rb1, wa1, wb1;
  logic [L1-2:0] tw1;
  logic [$clog2(L1)-1:0] st1;

  int checks = 0;
  int errors = 0;

  logic [31:0] o_rd, o_wr, o_busy, o_done, o_ra, o_rb, o_tw, o_wa, o_wb, o_st;

  always #5 clk = ~clk;

  fft_bf_sched #(.LOG2N(L0), .PIPE_LAT(P0)) dut0 (
    .clk(clk), .rst(rst),
`ifdef FFT_SCHED_STALL_EN
    .hold(hold),
`endif
    .start(start0), .busy(busy0), .done(done0), .rd_en(rd_en0),
    .rd_addr_a(ra0), .rd_addr_b(rb0), .tw_addr(tw0), .wr_en(wr_en0),
    .wr_addr_a(wa0), .wr_addr_b(wb0), .stage(st0)
  );

  fft_bf_sched #(.LOG2N(L1), .PIPE_LAT(P1)) dut1 (
    .clk(clk), .rst(rst),
`ifdef FFT_SCHED_STALL_EN
    .hold(hold),
`endif
    .start(start1), .busy(busy1), .done(done1), .rd_en(rd_en1),
    .rd_addr_a(ra1), .rd_addr_b(rb1), .tw_addr(tw1), .wr_en(wr_en1),
    .wr_addr_a(wa1), .wr_addr_b(wb1), .stage(st1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: cycle t counted from the first rd_en; stage s lasts N/2 issue cycles + p idle cycles.
  // Butterfly k of stage s pairs the k-th index (ascending) whose bit s is 0 with index + 2^s.
  function automatic void model(input int log2n, input int p, input int t,
                                output bit en, output int a, output int b,
                                output int tw, output int s);
    int n, seg, total, k, cnt;
    n = 1 << log2n;
    seg = n / 2 + p;
    total = log2n * seg;
    en = 0; a = 0; b = 0; tw = 0; s = 0;
    if (t < 0 || t >= total) return;
    s = t / seg;
    k = t % seg;
    if (k >= n / 2) return;
    en = 1;
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      if (((i >> s) & 1) == 0) begin
        if (cnt == k) begin
          a = i;
          break;
        end
        cnt++;
      end
    end
    b = a + (1 << s);
    tw = (a % (1 << s)) * (n / (2 << s));
  endfunction

  task automatic grab(input int inst);
    if (inst == 0) begin
      o_rd = 32'(rd_en0); o_wr = 32'(wr_en0); o_busy = 32'(busy0); o_done = 32'(done0);
      o_ra = 32'(ra0); o_rb = 32'(rb0); o_tw = 32'(tw0);
      o_wa = 32'(wa0); o_wb = 32'(wb0); o_st = 32'(st0);
    end else begin
      o_rd = 32'(rd_en1); o_wr = 32'(wr_en1); o_busy = 32'(busy1); o_done = 32'(done1);
      o_ra = 32'(ra1); o_rb = 32'(rb1); o_tw = 32'(tw1);
      o_wa = 32'(wa1); o_wb = 32'(wb1); o_st = 32'(st1);
    end
  endtask

  task automatic drive_start(input int inst, input logic v);
    if (inst == 0) start0 = v;
    else start1 = v;
  endtask

  // One transform: start pulse, then every cycle checked up to two cycles past done.
  // spurious=1 sprinkles extra start pulses, including on the done cycle.
  task automatic run(input int inst, input bit spurious, input int abort_t);
    int log2n, p, total, a, b, tw, s, wa, wb, wtw, ws;
    bit e_rd, e_wr;
    logic v;
    log2n = (inst == 0) ? L0 : L1;
    p = (inst == 0) ? P0 : P1;
    total = log2n * ((1 << log2n) / 2 + p);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    drive_start(inst, 1'b1);
    for (int t = -1; t <= total + 2; t++) begin
      @(negedge clk);
      grab(inst);
      model(log2n, p, t, e_rd, a, b, tw, s);
      model(log2n, p, t - p, e_wr, wa, wb, wtw, ws);
      chk($sformatf("i%0d t%0d rd_en", inst, t), o_rd, 32'(e_rd));
      chk($sformatf("i%0d t%0d wr_en", inst, t), o_wr, 32'(e_wr));
      chk($sformatf("i%0d t%0d busy", inst, t), o_busy, 32'(t >= 0 && t < total));
      chk($sformatf("i%0d t%0d done", inst, t), o_done, 32'(t == total));
      if (e_rd) begin
        chk($sformatf("i%0d t%0d rd_addr_a", inst, t), o_ra, a);
        chk($sformatf("i%0d t%0d rd_addr_b", inst, t), o_rb, b);
        chk($sformatf("i%0d t%0d tw_addr", inst, t), o_tw, tw);
        chk($sformatf("i%0d t%0d stage", inst, t), o_st, s);
      end
      if (e_wr) begin
        chk($sformatf("i%0d t%0d wr_addr_a", inst, t), o_wa, wa);
        chk($sformatf("i%0d t%0d wr_addr_b", inst, t), o_wb, wb);
      end
      if (t == abort_t) begin
        $display("transform inst=%0d LOG2N=%0d PIPE_LAT=%0d aborted at t=%0d", inst, log2n, p, t);
        return;
      end
      v = 1'b0;
      if (spurious && t < total) v = ($urandom_range(0, 2) == 0);
      if (spurious && t == total) v = 1'b1;
      drive_start(inst, v);
    end
    $display("transform inst=%0d LOG2N=%0d PIPE_LAT=%0d spurious=%0d done_at=%0d", inst, log2n, p, spurious, total);
  endtask

  task automatic chk_all_zero(input int inst, input string tag);
    grab(inst);
    chk({tag, " rd_en"}, o_rd, 0);
    chk({tag, " wr_en"}, o_wr, 0);
    chk({tag, " busy"}, o_busy, 0);
    chk({tag, " done"}, o_done, 0);
    chk({tag, " rd_addr_a"}, o_ra, 0);
    chk({tag, " rd_addr_b"}, o_rb, 0);
    chk({tag, " tw_addr"}, o_tw, 0);
    chk({tag, " wr_addr_a"}, o_wa, 0);
    chk({tag, " wr_addr_b"}, o_wb, 0);
    chk({tag, " stage"}, o_st, 0);
  endtask

  initial begin
    int seg0;
    rst = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
`ifdef FFT_SCHED_STALL_EN
    hold = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk_all_zero(0, "reset0");
    chk_all_zero(1, "reset1");
    rst = 1'b0;
    $display("reset released");

    run(0, 1'b0, -2);
    run(0, 1'b1, -2);
    run(0, 1'b0, -2);

    // Asynchronous reset partway through stage 1 issue
    seg0 = (1 << L0) / 2 + P0;
    run(0, 1'b0, seg0 + int'($urandom_range(0, (1 << L0) / 2 - 1)));
    #2 rst = 1'b1;
    #1 chk_all_zero(0, "async_rst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < P0 + 3; i++) begin
      @(negedge clk);
      grab(0);
      chk($sformatf("post_rst c%0d wr_en", i), o_wr, 0);
      chk($sformatf("post_rst c%0d rd_en", i), o_rd, 0);
      chk($sformatf("post_rst c%0d busy", i), o_busy, 0);
    end
    $display("reset during stage 1 checked");
    run(0, 1'b0, -2);

    run(1, 1'b0, -2);
    run(1, 1'b1, -2);
    run(1, 1'b0, -2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_bf_sched.md
# fft_bf_sched

In-place radix-2 decimation-in-time scheduler for the FFT butterfly datapath. It sequences all LOG2N stages of an N-point transform over a dual-port sample RAM: one butterfly pair issued per cycle, plus the twiddle ROM address for that pair. Read addresses are delayed to form write-back addresses that match the butterfly pipeline. The block sits between the FFT top-level control (start/done) and the RAM, twiddle ROM and butterfly pipeline. Input data is already in bit-reversed order in RAM.

## Interface
- LOG2N, 8, log2 of transform length N; N = 2^LOG2N, legal 2..12
- PIPE_LAT, 4, cycles from rd_en to the matching wr_en (RAM read + twiddle multiply + butterfly), legal 1..16
- clk  in  1  system clock, all logic rising-edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to run a full transform
- busy  out  1  high while a transform is in progress
- done  out  1  one-cycle pulse when the last write-back of the last stage issues
- rd_en  out  1  read strobe for the butterfly pair
- rd_addr_a / rd_addr_b  out  LOG2N each  upper/lower operand addresses
- tw_addr  out  LOG2N-1  twiddle ROM index for the pair being read
- wr_en  out  1  write-back strobe
- wr_addr_a / wr_addr_b  out  LOG2N each  write-back addresses (rd addresses delayed PIPE_LAT)
- stage  out  $clog2(LOG2N)  current stage index, for debug and scaling

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: start=1 -> RUN, stage=0, k=0. start is ignored in every other state.
- RUN: each cycle rd_en=1 for butterfly k (0..N/2-1). When k = N/2-1 has issued, go to DRAIN with a drain count of 0.
- DRAIN: rd_en=0 for exactly PIPE_LAT cycles, which prevents read-after-write hazards across stages. On the last DRAIN cycle:
  - if stage < LOG2N-1: stage+1, k=0, go to RUN;
  - otherwise go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Address math for stage s, span = 2^s:
  - pos = k & (span-1), grp = k >> s
  - rd_addr_a = (grp << (s+1)) | pos
  - rd_addr_b = rd_addr_a + span
  - tw_addr = pos << (LOG2N-1-s)
  - All arithmetic is unsigned and truncated to the port width.
- Write path: {rd_en, rd_addr_a, rd_addr_b} passes through a PIPE_LAT-deep shift register to give {wr_en, wr_addr_a, wr_addr_b}.
- Reset values: busy=0, done=0, rd_en=0, wr_en=0, all addresses 0, stage=0, state IDLE, delay line cleared.
- Reset mid-transform: no further wr_en is emitted and pending writes are discarded.

## Timing
- start sampled at edge T: busy=1 and first rd_en=1 (stage 0, k=0) are both registered outputs valid after edge T+1.
- Each wr_en follows its rd_en exactly PIPE_LAT cycles later.
- A stage occupies N/2 RUN cycles + PIPE_LAT DRAIN cycles. The last write of a stage coincides with the last DRAIN cycle.
- done is asserted the cycle after the final DRAIN cycle. busy drops together with done, i.e. busy=0 from the cycle done is high.
- Total transform time: LOG2N*(N/2+PIPE_LAT) cycles from first rd_en to the done cycle, inclusive of the final drain. At N=8, PIPE_LAT=4 this is 24.
- A start coincident with done is ignored. A new start is accepted from the following IDLE cycle.

## Configuration
- FFT_SCHED_STALL_EN defined:
  - Adds input hold (1 bit).
  - While hold=1, the FSM, k counter, drain counter and delay line all freeze.
  - rd_en and wr_en are forced 0 while hold=1. Addresses hold their values.
  - Issue resumes on the next cycle after hold falls; the relative rd-to-wr spacing of PIPE_LAT active cycles is preserved.
- FFT_SCHED_STALL_EN undefined: there is no hold port and the block never stalls.

## Structure
- fft_inc.h gains the FSM state encodings (SCHED_IDLE/RUN/DRAIN/DONE) and the default LOG2N/PIPE_LAT values, alongside the existing CPLX_WIDTH.
- One sub-module, bf_addr_delay: a parameterised PIPE_LAT-stage shift register carrying valid plus the two addresses. It has its own async reset, and an enable used by the stall option.

## Test plan
- N=8, PIPE_LAT=4, start pulse -> stage 0 reads (0,1)(2,3)(4,5)(6,7), tw 0,0,0,0; stage 1 reads (0,2)(1,3)(4,6)(5,7), tw 0,2,0,2; stage 2 reads (0,4)(1,5)(2,6)(3,7), tw 0,1,2,3.
- Same run -> each wr_en lands 4 cycles after its rd_en with identical addresses; no rd_en during the 4 drain cycles; done arrives 24 cycles after the first rd_en.
- start pulsed again mid-transform and on the done cycle -> ignored; sequence unchanged; a later start in IDLE restarts at stage 0.
- rst asserted during stage 1 RUN -> all outputs 0 asynchronously; no wr_en after release; next start begins a fresh transform.
- LOG2N=2, PIPE_LAT=1 -> reads (0,1)(2,3) then (0,2)(1,3), tw 0,0 then 0,1; total 6 cycles.
- With FFT_SCHED_STALL_EN, hold=1 for 3 cycles mid stage 0 -> rd_en and wr_en are 0 during hold, the sequence resumes unchanged, and the total length grows by exactly 3.
